// File: rtl/integ_accum.sv
// integ_accum: running-sum integrator with an optional integrate-and-dump window.
// Each valid sample is sign-extended, registered, then added to a signed
// accumulator. The sum is emitted with a one-cycle valid strobe two cycles
// after the sample is presented.
// Optional feature macro: INTEG_SAT_EN (saturate on overflow instead of wrapping).
module integ_accum #(
  parameter int WIDTH  = 12,
  parameter int OWIDTH = 16,
  parameter int LEN    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              ivalid,
  input  logic [WIDTH-1:0]  idata,
  output logic              ovalid,
  output logic [OWIDTH-1:0] odata,
  output logic              olast,
  output logic              oflow
);

  localparam int CW = $clog2(LEN) + 1;
  localparam logic [CW-1:0] LAST_CNT = (LEN > 0) ? CW'(LEN - 1) : '0;

  logic              v1;
  logic [OWIDTH-1:0] x1;
  logic [OWIDTH-1:0] x_ext;
  logic [OWIDTH-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [OWIDTH:0]   s;
  logic [OWIDTH-1:0] r;
  logic              ovf;
  logic              is_last;

  assign x_ext = OWIDTH'($signed(idata));

  // Stage 1: capture the sign-extended sample and its valid bit; clear flushes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1 <= 1'b0;
      x1 <= '0;
    end else if (clear) begin
      v1 <= 1'b0;
    end else begin
      v1 <= ivalid;
      if (ivalid) begin
        x1 <= x_ext;
      end
    end
  end

  // Stage 2 arithmetic: one-bit-wider sum, overflow detection and resolution.
  always_comb begin
    s       = {acc[OWIDTH-1], acc} + {x1[OWIDTH-1], x1};
    ovf     = s[OWIDTH] ^ s[OWIDTH-1];
    r       = s[OWIDTH-1:0];
    is_last = (LEN > 0) && (cnt == LAST_CNT);
`ifdef INTEG_SAT_EN
    if (ovf) begin
      if (s[OWIDTH]) begin
        r = {1'b1, {(OWIDTH-1){1'b0}}};
      end else begin
        r = {1'b0, {(OWIDTH-1){1'b1}}};
      end
    end
`endif
  end

  // Stage 2 registers: publish the sum and either keep it or dump at window end.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovalid <= 1'b0;
      odata  <= '0;
      olast  <= 1'b0;
      oflow  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else if (clear) begin
      ovalid <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      ovalid <= v1;
      if (v1) begin
        odata <= r;
        oflow <= ovf;
        olast <= is_last;
        if (is_last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= r;
          if (LEN > 0) begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_integ_accum.sv
// tb_integ_accum: table-driven bench for integ_accum. Three instances cover
// the free-running build (LEN=0), a dump window (LEN=4) and a narrow
// accumulator (OWIDTH=12) for overflow. Each record holds one cycle of
// inputs for one instance plus the outputs expected right after the edge
// that samples those inputs (i.e. the result of the previous record's input).
module tb_integ_accum;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst [3];
  logic        clr [3];
  logic        iv  [3];
  logic [11:0] id  [3];

  logic               ovalid0, olast0, oflow0;
  logic signed [15:0] odata0;
  logic               ovalid1, olast1, oflow1;
  logic signed [15:0] odata1;
  logic               ovalid2, olast2, oflow2;
  logic signed [11:0] odata2;

  integ_accum #(.WIDTH(12), .OWIDTH(16), .LEN(0)) dut0 (
    .clock(clock), .reset(rst[0]), .clear(clr[0]), .ivalid(iv[0]), .idata(id[0]),
    .ovalid(ovalid0), .odata(odata0), .olast(olast0), .oflow(oflow0));

  integ_accum #(.WIDTH(12), .OWIDTH(16), .LEN(4)) dut1 (
    .clock(clock), .reset(rst[1]), .clear(clr[1]), .ivalid(iv[1]), .idata(id[1]),
    .ovalid(ovalid1), .odata(odata1), .olast(olast1), .oflow(oflow1));

  integ_accum #(.WIDTH(12), .OWIDTH(12), .LEN(0)) dut2 (
    .clock(clock), .reset(rst[2]), .clear(clr[2]), .ivalid(iv[2]), .idata(id[2]),
    .ovalid(ovalid2), .odata(odata2), .olast(olast2), .oflow(oflow2));

  typedef struct {
    int sel;
    bit rst;
    bit clr;
    bit iv;
    int d;
    bit ev;
    int eo;
    bit el;
    bit ef;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

`ifdef INTEG_SAT_EN
  localparam int OV_D2 = 2047;  localparam bit OV_F2 = 1'b1;
  localparam int OV_D3 = -1;    localparam bit OV_F3 = 1'b0;
  localparam int OV_D4 = -2048; localparam bit OV_F4 = 1'b1;
`else
  localparam int OV_D2 = -2;    localparam bit OV_F2 = 1'b1;
  localparam int OV_D3 = 2046;  localparam bit OV_F3 = 1'b1;
  localparam int OV_D4 = -2;    localparam bit OV_F4 = 1'b0;
`endif

  task automatic addVec(input int sel, input bit r, input bit c, input bit v, input int d,
                        input bit ev, input int eo, input bit el, input bit ef);
    vec_t t;
    t.sel = sel; t.rst = r; t.clr = c; t.iv = v; t.d = d;
    t.ev = ev; t.eo = eo; t.el = el; t.ef = ef;
    tbl.push_back(t);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic ov, ol, of;
    int   od;
    bit   bad;
    case (v.sel)
      0:       begin ov = ovalid0; od = odata0; ol = olast0; of = oflow0; end
      1:       begin ov = ovalid1; od = odata1; ol = olast1; of = oflow1; end
      default: begin ov = ovalid2; od = odata2; ol = olast2; of = oflow2; end
    endcase
    nvec++;
    bad = 1'b0;
    if (ov !== v.ev) bad = 1'b1;
    if (v.ev && ((od != v.eo) || (ol !== v.el) || (of !== v.ef))) bad = 1'b1;
    if (v.rst && ((od != 0) || (ol !== 1'b0) || (of !== 1'b0))) bad = 1'b1;
    if (bad) begin
      nerr++;
      $display("[TB] FAIL vec%0d dut%0d: got ovalid=%0b odata=%0d olast=%0b oflow=%0b, want ovalid=%0b odata=%0d olast=%0b oflow=%0b",
               idx, v.sel, ov, od, ol, of, v.ev, v.eo, v.el, v.ef);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; clr[k] = 1'b0; iv[k] = 1'b0; id[k] = '0;
    end
    rst[v.sel] = v.rst;
    clr[v.sel] = v.clr;
    iv[v.sel]  = v.iv;
    id[v.sel]  = 12'(v.d);
    @(posedge clock);
    #1;
    checkOutput(v, idx);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; clr[k] = 1'b0; iv[k] = 1'b0; id[k] = '0;
    end
    repeat (2) @(posedge clock);

    // reset state of every instance
    addVec(0, 1, 0, 0, 0,   0, 0, 0, 0);
    addVec(1, 1, 0, 0, 0,   0, 0, 0, 0);
    addVec(2, 1, 0, 0, 0,   0, 0, 0, 0);
    // basic sum with gaps
    addVec(0, 0, 0, 1, 5,   0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,   1, 5, 0, 0);
    addVec(0, 0, 0, 1, 10,  0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,   1, 15, 0, 0);
    addVec(0, 0, 0, 1, 7,   0, 0, 0, 0);
    addVec(0, 0, 0, 1, 0,   1, 22, 0, 0);
    addVec(0, 0, 0, 0, 0,   1, 22, 0, 0);
    addVec(0, 0, 0, 1, -3,  0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,   1, 19, 0, 0);
    addVec(0, 0, 0, 0, 0,   0, 0, 0, 0);
    // round trip of first differences
    addVec(0, 0, 1, 0, 0,   0, 0, 0, 0);
    addVec(0, 0, 0, 1, 5,   0, 0, 0, 0);
    addVec(0, 0, 0, 1, 5,   1, 5, 0, 0);
    addVec(0, 0, 0, 1, -3,  1, 10, 0, 0);
    addVec(0, 0, 0, 1, -7,  1, 7, 0, 0);
    addVec(0, 0, 0, 1, -3,  1, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,   1, -3, 0, 0);
    addVec(0, 0, 0, 0, 0,   0, 0, 0, 0);
    // clear mid-stream: 200 is still in stage 1 and is flushed, 50 is discarded
    addVec(0, 0, 1, 0, 0,   0, 0, 0, 0);
    addVec(0, 0, 0, 1, 100, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 200, 1, 100, 0, 0);
    addVec(0, 0, 1, 1, 50,  0, 0, 0, 0);
    addVec(0, 0, 0, 1, 7,   0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,   1, 7, 0, 0);
    addVec(0, 0, 0, 0, 0,   0, 0, 0, 0);
    // dump window LEN=4, back-to-back restart
    addVec(1, 0, 0, 1, 1,   0, 0, 0, 0);
    addVec(1, 0, 0, 1, 2,   1, 1, 0, 0);
    addVec(1, 0, 0, 1, 3,   1, 3, 0, 0);
    addVec(1, 0, 0, 1, 4,   1, 6, 0, 0);
    addVec(1, 0, 0, 1, 5,   1, 10, 1, 0);
    addVec(1, 0, 0, 1, 6,   1, 5, 0, 0);
    addVec(1, 0, 0, 0, 0,   1, 11, 0, 0);
    addVec(1, 0, 0, 0, 0,   0, 0, 0, 0);
    // reset mid-window
    addVec(1, 1, 0, 0, 0,   0, 0, 0, 0);
    addVec(1, 0, 0, 1, 1,   0, 0, 0, 0);
    addVec(1, 0, 0, 1, 2,   1, 1, 0, 0);
    addVec(1, 1, 0, 0, 0,   0, 0, 0, 0);
    addVec(1, 0, 0, 1, 3,   0, 0, 0, 0);
    addVec(1, 0, 0, 1, 4,   1, 3, 0, 0);
    addVec(1, 0, 0, 1, 5,   1, 7, 0, 0);
    addVec(1, 0, 0, 1, 6,   1, 12, 0, 0);
    addVec(1, 0, 0, 0, 0,   1, 18, 1, 0);
    addVec(1, 0, 0, 0, 0,   0, 0, 0, 0);
    // overflow on the 12-bit accumulator
    addVec(2, 0, 0, 1, 2047,  0, 0, 0, 0);
    addVec(2, 0, 0, 1, 2047,  1, 2047, 0, 0);
    addVec(2, 0, 0, 1, -2048, 1, OV_D2, 0, OV_F2);
    addVec(2, 0, 0, 1, -2048, 1, OV_D3, 0, OV_F3);
    addVec(2, 0, 0, 0, 0,     1, OV_D4, 0, OV_F4);
    addVec(2, 0, 0, 0, 0,     0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
